// File: rtl/core_mem_arbiter_if.sv
// rtl/core_mem_arbiter_if.sv - shared data-memory port bundle
// Signals:
//   mem_req      master->slave  request, held until mem_ack
//   mem_we       master->slave  1 = write, 0 = read
//   mem_addr     master->slave  latched address
//   mem_wr_data  master->slave  latched write data
//   mem_ack      slave->master  one-cycle completion
//   mem_rd_data  slave->master  read data, valid with mem_ack
interface core_mem_arbiter_if #(
  parameter int ADDR_SIZE = 12,
  parameter int REG_SIZE  = 8
);
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [REG_SIZE-1:0]  mem_wr_data;
  logic                 mem_ack;
  logic [REG_SIZE-1:0]  mem_rd_data;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wr_data,
    input  mem_ack, mem_rd_data
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wr_data,
    output mem_ack, mem_rd_data
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - round-robin arbiter sharing one data-memory port among cores
// Ports:
//   clk, reset    clock (posedge) and asynchronous active-low reset
//   core_enable   per core 2 bits: 00 idle, 01 read, 10 write, 11 ignored
//   core_addr     per core ADDR_SIZE address slice
//   core_wr_data  per core REG_SIZE write data slice
//   rd_data       read data broadcast to all cores
//   val           one-hot completion strobe
//   busy          high whenever a transaction is in progress
//   timeout_err   watchdog abort pulse (only with CORE_MEM_ARB_TIMEOUT_EN)
//   mem           memory-side bundle (core_mem_arbiter_if.master)
// Optional feature macro: CORE_MEM_ARB_TIMEOUT_EN enables the ISSUE watchdog.
module core_mem_arbiter #(
  parameter int CORE_COUNT     = 4,
  parameter int ADDR_SIZE      = 12,
  parameter int REG_SIZE       = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [2*CORE_COUNT-1:0]        core_enable,
  input  logic [ADDR_SIZE*CORE_COUNT-1:0] core_addr,
  input  logic [REG_SIZE*CORE_COUNT-1:0] core_wr_data,
  output logic [REG_SIZE-1:0]            rd_data,
  output logic [CORE_COUNT-1:0]          val,
  output logic                           busy,
`ifdef CORE_MEM_ARB_TIMEOUT_EN
  output logic                           timeout_err,
`endif
  core_mem_arbiter_if.master             mem
);

  localparam int GW = $clog2(CORE_COUNT);

  if (CORE_COUNT < 2 || CORE_COUNT > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("core_mem_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state, state_next;
  logic [GW-1:0]   grant_idx;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   pick_idx;
  logic [GW-1:0]   scan_idx;
  logic            pick_found;
  logic [CORE_COUNT-1:0] req;
  logic            start_txn;
  logic            mem_done;
  logic            watchdog_fire;

  // 01 and 10 are requests; 00 and 11 are not.
  for (genvar i = 0; i < CORE_COUNT; i++) begin : g_req
    assign req[i] = core_enable[2*i] ^ core_enable[2*i+1];
  end

  // Scan offsets from the far end down so the nearest requester after
  // last_grant is the final (winning) assignment.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_grant;
    scan_idx   = last_grant;
    for (int k = CORE_COUNT; k >= 1; k--) begin
      scan_idx = GW'((int'(last_grant) + k) % CORE_COUNT);
      if (req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

`ifdef CORE_MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_count;

  // Counts ISSUE cycles; fires on the last allowed cycle so mem_req is
  // high for exactly TIMEOUT_CYCLES cycles. A late ack still wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_count <= '0;
    end else if (state != ISSUE) begin
      wd_count <= '0;
    end else begin
      wd_count <= wd_count + 1'b1;
    end
  end

  assign watchdog_fire = (state == ISSUE) && !mem.mem_ack &&
                         (wd_count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= mem_done && !mem.mem_ack;
    end
  end
`else
  assign watchdog_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start_txn  = 1'b0;
    mem_done   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next = ISSUE;
          start_txn  = 1'b1;
        end
      end
      ISSUE: begin
        if (mem.mem_ack || watchdog_fire) begin
          state_next = RESP;
          mem_done   = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_idx       <= '0;
      last_grant      <= GW'(CORE_COUNT - 1);
      rd_data         <= '0;
      val             <= '0;
      mem.mem_req     <= 1'b0;
      mem.mem_we      <= 1'b0;
      mem.mem_addr    <= '0;
      mem.mem_wr_data <= '0;
    end else begin
      val <= '0;
      if (start_txn) begin
        grant_idx       <= pick_idx;
        mem.mem_req     <= 1'b1;
        mem.mem_we      <= (core_enable[2*pick_idx +: 2] == 2'b10);
        mem.mem_addr    <= core_addr[pick_idx*ADDR_SIZE +: ADDR_SIZE];
        mem.mem_wr_data <= core_wr_data[pick_idx*REG_SIZE +: REG_SIZE];
      end
      if (mem_done) begin
        mem.mem_req    <= 1'b0;
        val[grant_idx] <= 1'b1;
        // No ack here means the watchdog aborted the access.
        if (!mem.mem_ack) begin
          rd_data <= '0;
        end else if (!mem.mem_we) begin
          rd_data <= mem.mem_rd_data;
        end
      end
      if (state == RESP) begin
        last_grant <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - self-checking bench for core_mem_arbiter
module tb_core_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 8;
`ifdef CORE_MEM_ARB_TIMEOUT_EN
  localparam int LONG_DLY = 7;
`else
  localparam int LONG_DLY = 10;
`endif

  logic            clk;
  logic            reset;
  logic [2*N-1:0]  core_enable;
  logic [AW*N-1:0] core_addr;
  logic [DW*N-1:0] core_wr_data;
  logic [DW-1:0]   rd_data;
  logic [N-1:0]    val;
  logic            busy;
`ifdef CORE_MEM_ARB_TIMEOUT_EN
  logic            timeout_err;
`endif

  core_mem_arbiter_if #(.ADDR_SIZE(AW), .REG_SIZE(DW)) mif ();

  core_mem_arbiter #(
    .CORE_COUNT(N), .ADDR_SIZE(AW), .REG_SIZE(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .core_enable(core_enable),
    .core_addr(core_addr),
    .core_wr_data(core_wr_data),
    .rd_data(rd_data),
    .val(val),
    .busy(busy),
`ifdef CORE_MEM_ARB_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .mem(mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_rd;
  logic [AW-1:0] base_addr [N];
  logic [DW-1:0] base_wd [N];

  typedef struct {
    logic [2*N-1:0] en;
    int             dly;
    logic [DW-1:0]  rdat;
    int             g;
    logic           we;
  } row_t;
  row_t rows [11];

  typedef struct {
    logic [1:0]    en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } op_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  task automatic run_row(input int n, input row_t r);
    core_enable = r.en;
    @(negedge clk);
    check($sformatf("row%0d_addr", n), mif.mem_addr, base_addr[r.g]);
    check($sformatf("row%0d_we", n), mif.mem_we, r.we);
    if (r.we) check($sformatf("row%0d_wdata", n), mif.mem_wr_data, base_wd[r.g]);
    for (int c = 1; c <= r.dly; c++) begin
      check($sformatf("row%0d_req_hold", n), mif.mem_req, 1'b1);
      check($sformatf("row%0d_addr_hold", n), mif.mem_addr, base_addr[r.g]);
      check($sformatf("row%0d_no_val", n), val, '0);
      if (c == r.dly) begin
        mif.mem_ack     = 1'b1;
        mif.mem_rd_data = r.rdat;
      end
      @(negedge clk);
      mif.mem_ack = 1'b0;
    end
    if (!r.we) exp_rd = r.rdat;
    check($sformatf("row%0d_val", n), val, onehot(r.g));
    check($sformatf("row%0d_req_low", n), mif.mem_req, 1'b0);
    check($sformatf("row%0d_rd", n), rd_data, exp_rd);
    core_enable = '0;
    @(negedge clk);
    check($sformatf("row%0d_val_once", n), val, '0);
    check($sformatf("row%0d_idle", n), busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    op_t            pend [N];
    bit             has [N];
    op_t            gop;
    int             phase, cur, g, last, wait_cnt, cnt;
    logic [DW-1:0]  mem_model [4096];

    for (int i = 0; i < N; i++) begin
      base_addr[i] = AW'(12'h010 + i * 12'h0F1);
      base_wd[i]   = DW'(8'h10 + i * 8'h21);
    end
    base_addr[1] = 12'h123;
    for (int i = 0; i < N; i++) begin
      core_addr[i*AW +: AW]    = base_addr[i];
      core_wr_data[i*DW +: DW] = base_wd[i];
    end

    rows[0]  = '{8'hAA, 1, 8'hEE, 0, 1'b1};
    rows[1]  = '{8'hAA, 2, 8'hEE, 1, 1'b1};
    rows[2]  = '{8'hAA, 1, 8'hEE, 2, 1'b1};
    rows[3]  = '{8'hAA, 3, 8'hEE, 3, 1'b1};
    rows[4]  = '{8'h04, 1, 8'hA5, 1, 1'b0};
    rows[5]  = '{8'h11, 1, 8'h3C, 2, 1'b0};
    rows[6]  = '{8'h11, LONG_DLY, 8'h77, 0, 1'b0};
    rows[7]  = '{8'h11, 1, 8'h5E, 2, 1'b0};
    rows[8]  = '{8'h11, 2, 8'h0F, 0, 1'b0};
    rows[9]  = '{8'hC4, 1, 8'hD2, 1, 1'b0};
    rows[10] = '{8'h7B, 1, 8'hE1, 3, 1'b0};

    reset           = 1'b0;
    core_enable     = '0;
    mif.mem_ack     = 1'b0;
    mif.mem_rd_data = '0;
    exp_rd          = '0;
    repeat (3) @(negedge clk);
    check("rst_req", mif.mem_req, 1'b0);
    check("rst_val", val, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_rd", rd_data, '0);
    check("rst_we", mif.mem_we, 1'b0);
    check("rst_addr", mif.mem_addr, '0);
    check("rst_wdata", mif.mem_wr_data, '0);
    reset = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 11; n++) run_row(n, rows[n]);

`ifdef CORE_MEM_ARB_TIMEOUT_EN
    core_enable = 8'h01;
    @(negedge clk);
    cnt = 0;
    while (mif.mem_req && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    check("to_req_cycles", cnt, TO);
    check("to_err", timeout_err, 1'b1);
    check("to_val", val, onehot(0));
    check("to_rd", rd_data, '0);
    exp_rd = '0;
    core_enable = '0;
    @(negedge clk);
    check("to_err_pulse", timeout_err, 1'b0);
    check("to_val_once", val, '0);
`endif

    // Asynchronous reset in the middle of ISSUE.
    core_enable = 8'h20;
    @(negedge clk);
    check("ar_req_up", mif.mem_req, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("ar_req_async", mif.mem_req, 1'b0);
    check("ar_val_async", val, '0);
    check("ar_busy_async", busy, 1'b0);
    core_enable = 8'hAA;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("ar_first_addr", mif.mem_addr, base_addr[0]);
    mif.mem_ack     = 1'b1;
    mif.mem_rd_data = 8'h99;
    @(negedge clk);
    mif.mem_ack = 1'b0;
    check("ar_first_val", val, onehot(0));
    check("ar_rd_after_write", rd_data, '0);
    exp_rd = '0;
    core_enable = '0;
    @(negedge clk);

    // Randomized traffic against a transaction-level model.
    for (int a = 0; a < 4096; a++) mem_model[a] = DW'(a * 7 + 3);
    for (int i = 0; i < N; i++) has[i] = 1'b0;
    phase = 0;
    last  = 0;
    g     = 0;
    wait_cnt = 0;
    gop = '{2'b00, '0, '0};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      cur = phase;
      check("rnd_busy", busy, cur != 0);
      check("rnd_req", mif.mem_req, cur == 1);
      check("rnd_val", val, (cur == 2) ? onehot(g) : '0);
      check("rnd_rd", rd_data, exp_rd);
`ifdef CORE_MEM_ARB_TIMEOUT_EN
      check("rnd_no_timeout", timeout_err, 1'b0);
`endif
      if (cur == 1) begin
        check("rnd_addr", mif.mem_addr, gop.addr);
        check("rnd_we", mif.mem_we, gop.en == 2'b10);
        if (gop.en == 2'b10) check("rnd_wdata", mif.mem_wr_data, gop.wd);
      end

      mif.mem_ack = 1'b0;
      if (cur == 2) begin
        has[g] = 1'b0;
        last   = g;
        phase  = 0;
      end else if (cur == 1) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          mif.mem_ack = 1'b1;
          if (gop.en == 2'b10) begin
            mem_model[gop.addr] = gop.wd;
            mif.mem_rd_data     = DW'($urandom);
          end else begin
            mif.mem_rd_data = mem_model[gop.addr];
            exp_rd          = mem_model[gop.addr];
          end
          phase = 2;
        end
      end
      if (cur != 1 && $urandom_range(4) == 0) begin
        mif.mem_ack     = 1'b1;
        mif.mem_rd_data = DW'($urandom);
      end

      for (int i = 0; i < N; i++) begin
        if (!has[i] && $urandom_range(3) == 0) begin
          has[i]       = 1'b1;
          pend[i].en   = ($urandom_range(1) == 1) ? 2'b10 : 2'b01;
          pend[i].addr = AW'($urandom_range(15));
          pend[i].wd   = DW'($urandom);
        end
        if (has[i]) begin
          core_enable[2*i +: 2]    = pend[i].en;
          core_addr[i*AW +: AW]    = pend[i].addr;
          core_wr_data[i*DW +: DW] = pend[i].wd;
        end else begin
          core_enable[2*i +: 2]    = ($urandom_range(3) == 0) ? 2'b11 : 2'b00;
          core_addr[i*AW +: AW]    = AW'($urandom);
          core_wr_data[i*DW +: DW] = DW'($urandom);
        end
      end
      // The granted core may change or withdraw its lines mid-transaction.
      if (cur == 1 && $urandom_range(2) == 0) begin
        core_enable[2*g +: 2]    = 2'($urandom);
        core_addr[g*AW +: AW]    = AW'($urandom);
        core_wr_data[g*DW +: DW] = DW'($urandom);
      end

      if (cur == 0) begin
        for (int k = 1; k <= N; k++) begin
          if (phase == 0 && has[(last + k) % N]) begin
            g        = (last + k) % N;
            gop      = pend[g];
            wait_cnt = $urandom_range(6, 1);
            phase    = 1;
          end
        end
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
